aes_inv_cipher_iter: RTL and testbench
======================================

Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher (decryption) engine: one inverse round per clock.
- Computes InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns per FIPS-197 Sec. 5.3.
- Contains 16 parallel inverse S-box lookups; the inverse S-box table is hard-coded inside the block.
- Round keys come from an external key store, addressed by rk_idx.
- Sits on the decrypt side of the feedback cipher datapath, alongside the forward S-box/encrypt path.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); key store must hold NR+1 round keys.
- RK_IDX_W, 4, width of rk_idx; must satisfy 2**RK_IDX_W > NR.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  ciphertext block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  128  ciphertext; in_data[127:120] = byte 0, FIPS-197 column-major order.
- rk_idx  out  RK_IDX_W  round-key index requested this cycle.
- rk  in  128  round key for rk_idx; combinational, same cycle; same byte order as in_data.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  downstream accepts plaintext.
- out_data  out  128  plaintext, same byte order.
- busy  out  1  high in ROUND or FINAL.

Behaviour:
Interface:
- One clock. Reset is synchronous and active-high; ports are named clk and rst.
- rst has priority over all other inputs.

Reset values:
- State IDLE, round counter = NR.
- out_valid=0, out_data=0, busy=0.
- rk_idx=NR, in_ready=1 on the first cycle after rst deasserts.

State machine, IDLE -> ROUND -> FINAL -> DONE -> IDLE:
- IDLE: in_ready=1, rk_idx=NR.
  - On in_valid&&in_ready: state_reg <= in_data ^ rk; cnt <= NR-1; go to ROUND.
- ROUND: rk_idx=cnt. Each cycle: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk).
  - If cnt==1, go to FINAL; else cnt <= cnt-1.
  - Takes NR-1 cycles.
- FINAL: rk_idx=0. out_data <= InvSubBytes(InvShiftRows(state_reg)) ^ rk; out_valid <= 1; go to DONE.
- DONE: out_data stable and out_valid=1 until out_valid&&out_ready.
  - On that handshake: out_valid <= 0; go to IDLE.
  - in_ready=0 throughout DONE (base build).

Latency and throughput:
- Acceptance edge counts as edge 1; out_valid rises after edge NR+1 (11 for NR=10).
- Base-build throughput: one block per NR+2 cycles with out_ready tied high.

Arithmetic:
- InvMixColumns uses GF(2^8) with polynomial 0x11B; coefficients 0e,0b,0d,09, built from xtime chains (no multipliers).
- InvShiftRows rotates row r right by r bytes.

Boundary rules:
- in_valid while not IDLE: ignored, never latched.
- out_ready while out_valid=0: ignored.
- rst mid-ROUND or in DONE: block is discarded, out_valid drops on the next edge, no partial output.
- rk_idx changes only on clock edges; it is never X outside reset.

Optional Feature:
Macro: AES_INV_CIPHER_OUT_DECOUPLE_EN.
- Defined: out_data/out_valid form a separate output register.
  - FINAL writes that register and returns directly to IDLE; no DONE state.
  - IDLE accepts a new block while the previous result waits.
  - If FINAL is reached while out_valid=1 and out_ready=0, the engine stalls in FINAL: rk_idx held at 0, state_reg held.
  - It writes the register on the cycle the old result is consumed, or when out_valid is already 0.
  - Back-to-back throughput is one block per NR+1 cycles.
- Undefined: base behaviour as above.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, bench model supplies the schedule; in_data 3925841d02dc09fbdc118597196a0b32 -> out_data 3243f6a8885a308d313198a2e0370734, out_valid after edge 11, rk_idx sequence 10,9,...,1,0.
2. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f; in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
3. Backpressure: out_ready low for 20 cycles after out_valid -> out_data constant, in_ready=0 (base), a 2nd in_valid is not accepted; release -> single handshake, in_ready=1 next cycle.
4. Back-to-back: 8 random blocks, bench holds in_valid, out_ready=1 -> outputs match reference model in order, spacing 12 cycles (base) / 11 (macro defined).
5. Reset: assert rst during ROUND cycle 5 -> out_valid stays 0, next cycle in_ready=1, rk_idx=10; a subsequent App. B vector decrypts correctly.
6. Macro defined: out_ready=0 while a 2nd block is accepted -> engine holds in FINAL with rk_idx=0; release -> 1st result handshakes, 2nd appears the next cycle, both correct.

Source files
------------

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched via rk_idx.
// Optional AES_INV_CIPHER_OUT_DECOUPLE_EN: separate output register, FINAL returns straight to IDLE.
module aes_inv_cipher_iter #(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] IDX_ONE = RK_IDX_W'(1);

  // Listed byte 0 first, so entry b sits at packed index 255-b, i.e. ~b.
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

`ifdef AES_INV_CIPHER_OUT_DECOUPLE_EN
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;
`else
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;
`endif

  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    return INV_SBOX[~b];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a, m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    a = col;
    for (int i = 0; i < 4; i++) begin
      x2    = xt(a[3-i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[3-i];
      mb[i] = x8 ^ x2 ^ a[3-i];
      md[i] = x8 ^ x4 ^ a[3-i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Byte i is row i%4, column i/4; row r is rotated right by r before substitution.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sub(s[127-8*(4*(((i/4) - (i%4) + 4) % 4) + (i%4)) -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  state_e                fsm_q, fsm_d;
  logic [RK_IDX_W-1:0]   cnt_q, cnt_d, rk_idx_q, rk_idx_d;
  logic [127:0]          blk_q, blk_d, out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic [127:0]          shifted, final_out, round_out;

  always_comb begin
    shifted    = inv_shift_sub(blk_q);
    final_out  = shifted ^ rk;
    round_out  = inv_mix(final_out);
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef AES_INV_CIPHER_OUT_DECOUPLE_EN
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
`endif
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          blk_d = in_data ^ rk;
          cnt_d = NR_IDX - IDX_ONE;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = round_out;
        if (cnt_q == IDX_ONE) fsm_d = FINAL;
        else                  cnt_d = cnt_q - IDX_ONE;
      end
      FINAL: begin
`ifdef AES_INV_CIPHER_OUT_DECOUPLE_EN
        // Stall here until the previous result has left the output register.
        if (!out_valid_q || out_ready) begin
          out_data_d  = final_out;
          out_valid_d = 1'b1;
          cnt_d       = NR_IDX;
          fsm_d       = IDLE;
        end
`else
        out_data_d  = final_out;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
`endif
      end
`ifndef AES_INV_CIPHER_OUT_DECOUPLE_EN
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = NR_IDX;
          fsm_d       = IDLE;
        end
      end
`endif
      default: fsm_d = IDLE;
    endcase

    rk_idx_d   = NR_IDX;
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    case (fsm_d)
      IDLE:    in_ready_d = 1'b1;
      ROUND: begin
        rk_idx_d = cnt_d;
        busy_d   = 1'b1;
      end
      FINAL: begin
        rk_idx_d = '0;
        busy_d   = 1'b1;
      end
      default: rk_idx_d = NR_IDX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      cnt_q       <= NR_IDX;
      blk_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rk_idx_q    <= NR_IDX;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rk_idx    = rk_idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS-197 vectors plus random blocks against a
// table-derived AES reference model; honours AES_INV_CIPHER_OUT_DECOUPLE_EN when defined.
module tb_aes_inv_cipher_iter;

  localparam int NR = 10;
`ifdef AES_INV_CIPHER_OUT_DECOUPLE_EN
  localparam int B2B_PERIOD = NR + 1;
`else
  localparam int B2B_PERIOD = NR + 2;
`endif

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk, out_data;
  logic [3:0]   rk_idx;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rkeys [16];
  int           n_checks, n_fail;

  aes_inv_cipher_iter #(.NR(NR), .RK_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  // External key store: combinational lookup by the requested index.
  assign rk = rkeys[rk_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-boxes derived from the GF(2^8) inverse and the affine map.
  task automatic init_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    for (int r = 0; r < 16; r++) rkeys[r] = '0;
  endtask

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      if (r <= NR) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rkeys[r] = '0;
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   m [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [127:0] pt;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = ct[127-8*(4*c+r) -: 8] ^ rkeys[NR][127-8*(4*c+r) -: 8];
    for (int rnd = NR - 1; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = isbox[m[r][(c - r + 4) % 4]] ^ rkeys[rnd][127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd > 0) begin
            m[r][c] = 8'h00;
            for (int k = 0; k < 4; k++) m[r][c] = m[r][c] ^ gmul(coef[(k - r + 4) % 4], t[k][c]);
          end else begin
            m[r][c] = t[r][c];
          end
        end
    end
    pt = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) pt[127-8*(4*c+r) -: 8] = m[r][c];
    return pt;
  endfunction

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_output({tag, "_out_valid"}, 128'(out_valid), 128'(1));
  endtask

  // Full block with out_ready high: latency, rk_idx sequence, data and handshake.
  task automatic apply_stimulus(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt);
    int edges;
    out_ready = 1'b1;
    check_output({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check_output({tag, "_rk_idle"}, 128'(rk_idx), 128'(NR));
    in_valid = 1'b1;
    in_data  = ct;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      if (edges <= NR) begin
        check_output({tag, "_rk_idx"}, 128'(rk_idx), 128'(NR - edges));
        check_output({tag, "_busy"}, 128'(busy), 128'(1));
      end
      tick();
      edges++;
    end
    check_output({tag, "_latency"}, 128'(edges), 128'(NR + 1));
    check_output({tag, "_out_valid"}, 128'(out_valid), 128'(1));
    check_output({tag, "_out_data"}, out_data, exp_pt);
    tick();
    check_output({tag, "_handshake"}, 128'(out_valid), 128'(0));
    check_output({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] key, blk2, exp2;
    logic [127:0] blocks [8];
    logic [127:0] expq [$];
    int sent, recv, cyc, last_out;

    n_checks = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    init_tables();
    tick(); tick(); tick();
    rst = 1'b0;
    check_output("rst_out_valid", 128'(out_valid), 128'(0));
    check_output("rst_out_data", out_data, 128'(0));
    check_output("rst_busy", 128'(busy), 128'(0));
    check_output("rst_rk_idx", 128'(rk_idx), 128'(NR));
    check_output("rst_in_ready", 128'(in_ready), 128'(1));

    key_expand(KEY_B);
    apply_stimulus("appB", CT_B, PT_B);
    key_expand(KEY_C);
    apply_stimulus("appC", CT_C, PT_C);

    // Backpressure: result must hold while downstream stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = CT_C;
    tick();
    in_valid = 1'b0;
    wait_out_valid("bp");
    for (int i = 0; i < 20; i++) begin
`ifndef AES_INV_CIPHER_OUT_DECOUPLE_EN
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      check_output("bp_in_ready", 128'(in_ready), 128'(0));
`endif
      check_output("bp_out_data", out_data, PT_C);
      check_output("bp_out_valid", 128'(out_valid), 128'(1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output("bp_hold_final", out_data, PT_C);
    tick();
    check_output("bp_single_hs", 128'(out_valid), 128'(0));
    check_output("bp_in_ready_after", 128'(in_ready), 128'(1));
    tick(); tick();
    check_output("bp_not_latched_busy", 128'(busy), 128'(0));
    check_output("bp_not_latched_valid", 128'(out_valid), 128'(0));

    // Back-to-back random blocks under a random key.
    key = {$urandom, $urandom, $urandom, $urandom};
    key_expand(key);
    for (int i = 0; i < 8; i++) begin
      blocks[i] = {$urandom, $urandom, $urandom, $urandom};
      expq.push_back(ref_decrypt(blocks[i]));
    end
    sent = 0; recv = 0; cyc = 0; last_out = 0;
    out_ready = 1'b1;
    while (recv < 8 && cyc < 400) begin
      if (out_valid) begin
        check_output("b2b_data", out_data, expq.pop_front());
        if (recv > 0) check_output("b2b_spacing", 128'(cyc - last_out), 128'(B2B_PERIOD));
        last_out = cyc;
        recv++;
      end
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data  = blocks[sent];
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check_output("b2b_count", 128'(recv), 128'(8));
    tick(); tick();

    // Reset in the middle of ROUND discards the block.
    key_expand(KEY_B);
    in_valid = 1'b1;
    in_data  = CT_B;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check_output("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check_output("mid_rst_rk_idx", 128'(rk_idx), 128'(NR));
    check_output("mid_rst_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 15; i++) begin
      check_output("mid_rst_no_output", 128'(out_valid), 128'(0));
      tick();
    end
    apply_stimulus("appB_after_rst", CT_B, PT_B);

`ifdef AES_INV_CIPHER_OUT_DECOUPLE_EN
    // Second block stalls in FINAL behind an unconsumed first result.
    blk2 = {$urandom, $urandom, $urandom, $urandom};
    exp2 = ref_decrypt(blk2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = CT_B;
    tick();
    in_valid = 1'b0;
    wait_out_valid("dec1");
    check_output("dec_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = blk2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_output("dec_hold_data", out_data, PT_B);
    check_output("dec_hold_valid", 128'(out_valid), 128'(1));
    check_output("dec_stall_rk_idx", 128'(rk_idx), 128'(0));
    check_output("dec_stall_busy", 128'(busy), 128'(1));
    out_ready = 1'b1;
    tick();
    check_output("dec_second_valid", 128'(out_valid), 128'(1));
    check_output("dec_second_data", out_data, exp2);
    tick();
    check_output("dec_second_hs", 128'(out_valid), 128'(0));
`else
    blk2 = '0;
    exp2 = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
